// File: rtl/coproc_pkg.sv
// Shared constants and state encoding for the matrix-multiply stream coprocessor.
package coproc_pkg;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned A_DEPTH_BITS   = 3;
    localparam int unsigned B_DEPTH_BITS   = 2;
    localparam int unsigned RES_DEPTH_BITS = 1;
    localparam int unsigned AXIS_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_INPUTS   = 2'd1,
        COMPUTE       = 2'd2,
        WRITE_OUTPUTS = 2'd3
    } coproc_state_t;

endpackage

// File: rtl/res_stream_out.sv
// Streams RES_RAM out over AXIS: read counter -> 1-cycle RAM read -> output register.
module res_stream_out
    import coproc_pkg::*;
#(
    parameter int unsigned width          = WIDTH,
    parameter int unsigned RES_depth_bits = RES_DEPTH_BITS,
    parameter int unsigned axis_width     = AXIS_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    output logic                      done,
    input  logic                      m_tready,
    output logic [axis_width-1:0]     m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic                      rd_en,
    output logic [RES_depth_bits-1:0] rd_addr,
    input  logic [width-1:0]          rd_data
);

    localparam int unsigned RES_LEN = 1 << RES_depth_bits;

    logic active;
    logic issue_done;
    logic rd_pend;
    logic pend_last;
    logic advance;
    logic rd_is_last;

    assign advance    = !m_tvalid || m_tready;
    assign rd_en      = active && advance && !issue_done;
    assign rd_is_last = (rd_addr == RES_depth_bits'(RES_LEN - 1));

    // rd_pend stays set while a stalled output register holds off the RAM word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            issue_done <= 1'b0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            rd_addr    <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                active     <= 1'b1;
                issue_done <= 1'b0;
                rd_pend    <= 1'b0;
                pend_last  <= 1'b0;
                rd_addr    <= '0;
                m_tvalid   <= 1'b0;
                m_tlast    <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_addr   <= rd_addr + RES_depth_bits'(1);
                    pend_last <= rd_is_last;
                    if (rd_is_last) begin
                        issue_done <= 1'b1;
                    end
                end
                if (advance) begin
                    m_tvalid <= rd_pend;
                    m_tlast  <= rd_pend && pend_last;
                    if (rd_pend) begin
                        m_tdata <= axis_width'(rd_data);
                    end
                end
                rd_pend <= rd_en || (rd_pend && !advance);
                if (m_tvalid && m_tready && m_tlast) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coproc_stream_ctrl.sv
// AXIS front end of the matrix-multiply coprocessor: loads A/B RAMs, runs Start/Done, streams results.
// Optional TLAST framing check (frame_err port) enabled by defining COPROC_TLAST_CHECK_EN.
module coproc_stream_ctrl
    import coproc_pkg::*;
#(
    parameter int unsigned width          = WIDTH,
    parameter int unsigned A_depth_bits   = A_DEPTH_BITS,
    parameter int unsigned B_depth_bits   = B_DEPTH_BITS,
    parameter int unsigned RES_depth_bits = RES_DEPTH_BITS,
    parameter int unsigned axis_width     = AXIS_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [axis_width-1:0]     S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    input  logic                      S_AXIS_TLAST,
    output logic [axis_width-1:0]     M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic                      M_AXIS_TLAST,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
`ifdef COPROC_TLAST_CHECK_EN
    output logic                      frame_err,
`endif
    output logic                      Start,
    input  logic                      Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out
);

    localparam int unsigned A_LEN = 1 << A_depth_bits;
    localparam int unsigned B_LEN = 1 << B_depth_bits;

    coproc_state_t           state;
    logic [A_depth_bits-1:0] a_addr;
    logic [B_depth_bits-1:0] b_addr;
    logic                    in_b;
    logic                    beat;
    logic                    last_beat;
    logic                    res_go;
    logic                    res_done;
    logic                    unused_ok;

    assign beat      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign last_beat = in_b && (b_addr == B_depth_bits'(B_LEN - 1));

    // RAM write ports are driven straight from the accepted beat
    assign A_write_en      = beat && !in_b;
    assign B_write_en      = beat && in_b;
    assign A_write_address = a_addr;
    assign B_write_address = b_addr;
    assign A_write_data_in = A_write_en ? S_AXIS_TDATA[width-1:0] : '0;
    assign B_write_data_in = B_write_en ? S_AXIS_TDATA[width-1:0] : '0;

    assign unused_ok = ^{S_AXIS_TDATA[axis_width-1:width], S_AXIS_TLAST};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            S_AXIS_TREADY <= 1'b0;
            Start         <= 1'b0;
            a_addr        <= '0;
            b_addr        <= '0;
            in_b          <= 1'b0;
            res_go        <= 1'b0;
`ifdef COPROC_TLAST_CHECK_EN
            frame_err     <= 1'b0;
`endif
        end else begin
            res_go <= 1'b0;
            case (state)
                IDLE: begin
                    a_addr        <= '0;
                    b_addr        <= '0;
                    in_b          <= 1'b0;
                    S_AXIS_TREADY <= 1'b1;
                    state         <= READ_INPUTS;
                end
                READ_INPUTS: begin
                    if (beat) begin
                        if (!in_b) begin
                            a_addr <= a_addr + A_depth_bits'(1);
                            if (a_addr == A_depth_bits'(A_LEN - 1)) begin
                                in_b <= 1'b1;
                            end
                        end else begin
                            b_addr <= b_addr + B_depth_bits'(1);
                        end
`ifdef COPROC_TLAST_CHECK_EN
                        // early TLAST aborts the frame; missing final TLAST is only flagged
                        if (S_AXIS_TLAST && !last_beat) begin
                            frame_err     <= 1'b1;
                            S_AXIS_TREADY <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            if (!S_AXIS_TLAST && last_beat) begin
                                frame_err <= 1'b1;
                            end
                            if (last_beat) begin
                                S_AXIS_TREADY <= 1'b0;
                                Start         <= 1'b1;
                                state         <= COMPUTE;
                            end
                        end
`else
                        if (last_beat) begin
                            S_AXIS_TREADY <= 1'b0;
                            Start         <= 1'b1;
                            state         <= COMPUTE;
                        end
`endif
                    end
                end
                COMPUTE: begin
                    if (Done) begin
                        Start  <= 1'b0;
                        res_go <= 1'b1;
                        state  <= WRITE_OUTPUTS;
                    end
                end
                WRITE_OUTPUTS: begin
                    if (res_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    res_stream_out #(
        .width         (width),
        .RES_depth_bits(RES_depth_bits),
        .axis_width    (axis_width)
    ) u_res_stream_out (
        .clk     (clk),
        .reset   (reset),
        .go      (res_go),
        .done    (res_done),
        .m_tready(M_AXIS_TREADY),
        .m_tdata (M_AXIS_TDATA),
        .m_tvalid(M_AXIS_TVALID),
        .m_tlast (M_AXIS_TLAST),
        .rd_en   (RES_read_en),
        .rd_addr (RES_read_address),
        .rd_data (RES_read_data_out)
    );

endmodule

// File: tb/tb_coproc_stream_ctrl.sv
// Scoreboard bench for coproc_stream_ctrl with behavioural A/B/RES RAMs and a multiplier stand-in.
module tb_coproc_stream_ctrl;

    typedef logic [7:0] a_arr_t [8];
    typedef logic [7:0] b_arr_t [4];
    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic        A_write_en;
    logic [2:0]  A_write_address;
    logic [7:0]  A_write_data_in;
    logic        B_write_en;
    logic [1:0]  B_write_address;
    logic [7:0]  B_write_data_in;
    logic        Start;
    logic        Done;
    logic        RES_read_en;
    logic [0:0]  RES_read_address;
    logic [7:0]  RES_read_data_out;
`ifdef COPROC_TLAST_CHECK_EN
    logic        frame_err;
`endif

    int   total = 0;
    int   bad = 0;
    int   a_idx = 0;
    int   b_idx = 0;
    int   rdy_mode = 0;
    exp_t exp_q[$];

    logic [7:0] a_ram [8];
    logic [7:0] b_ram [4];
    logic [7:0] res_ram [2];
    logic [7:0] res_rd = 8'h00;

    always #5 clk = ~clk;

    coproc_stream_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .S_AXIS_TDATA     (S_AXIS_TDATA),
        .S_AXIS_TVALID    (S_AXIS_TVALID),
        .S_AXIS_TREADY    (S_AXIS_TREADY),
        .S_AXIS_TLAST     (S_AXIS_TLAST),
        .M_AXIS_TDATA     (M_AXIS_TDATA),
        .M_AXIS_TVALID    (M_AXIS_TVALID),
        .M_AXIS_TREADY    (M_AXIS_TREADY),
        .M_AXIS_TLAST     (M_AXIS_TLAST),
        .A_write_en       (A_write_en),
        .A_write_address  (A_write_address),
        .A_write_data_in  (A_write_data_in),
        .B_write_en       (B_write_en),
        .B_write_address  (B_write_address),
        .B_write_data_in  (B_write_data_in),
`ifdef COPROC_TLAST_CHECK_EN
        .frame_err        (frame_err),
`endif
        .Start            (Start),
        .Done             (Done),
        .RES_read_en      (RES_read_en),
        .RES_read_address (RES_read_address),
        .RES_read_data_out(RES_read_data_out)
    );

    assign RES_read_data_out = res_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // RAM models: synchronous writes, RES read with 1-cycle latency holding when not enabled
    always @(posedge clk) begin
        if (A_write_en) a_ram[A_write_address] <= A_write_data_in;
        if (B_write_en) b_ram[B_write_address] <= B_write_data_in;
        if (RES_read_en) res_rd <= res_ram[RES_read_address];
    end

    // multiplier stand-in: Done pulses on the 5th cycle Start has been high
    initial begin
        int   st_cnt;
        logic done_prev;
        st_cnt = 0;
        Done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            done_prev = Done;
            Done = 1'b0;
            if (done_prev && !reset) check("start_after_done", 32'(Start), 0);
            if (Start && !reset) begin
                st_cnt++;
                if (st_cnt == 5) begin
                    for (int i = 0; i < 2; i++) begin
                        logic [7:0] acc;
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc + a_ram[i*4+k] * b_ram[k];
                        res_ram[i] = acc;
                    end
                    Done = 1'b1;
                end
            end else begin
                st_cnt = 0;
            end
        end
    end

    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            int cyc;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy_mode == 1) M_AXIS_TREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
            else M_AXIS_TREADY = 1'b1;
        end
    end

    // write-side monitor: enables only on beats, addresses follow beat order
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (A_write_en || B_write_en)) begin
                check("we_on_beat", 32'(S_AXIS_TVALID && S_AXIS_TREADY), 1);
                if (A_write_en) begin
                    check("a_wr_addr", 32'(A_write_address), 32'(a_idx));
                    a_idx = (a_idx + 1) % 8;
                end
                if (B_write_en) begin
                    check("b_wr_addr", 32'(B_write_address), 32'(b_idx));
                    b_idx = (b_idx + 1) % 4;
                end
            end
        end
    end

    // output monitor: pops the scoreboard on each handshake and checks stall stability
    initial begin
        logic        stall_prev;
        logic [31:0] data_prev;
        logic        last_prev;
        exp_t        e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_tvalid", 32'(M_AXIS_TVALID), 1);
                    check("stall_tdata", M_AXIS_TDATA, data_prev);
                    check("stall_tlast", 32'(M_AXIS_TLAST), 32'(last_prev));
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word actual=%0d required=none", M_AXIS_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", M_AXIS_TDATA, e.data);
                        check("tlast", 32'(M_AXIS_TLAST), 32'(e.last));
                    end
                end
                stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
                data_prev  = M_AXIS_TDATA;
                last_prev  = M_AXIS_TLAST;
            end
        end
    end

    task automatic send_word(input logic [7:0] w, input logic last);
        logic hs;
        int   n;
        S_AXIS_TDATA  = {24'($urandom), w};
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TLAST  = last;
        n = 0;
        do begin
            @(negedge clk);
            hs = S_AXIS_TREADY;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) check("s_tready_timeout", 0, 1);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input a_arr_t a, input b_arr_t b, input bit gap);
        a_idx = 0;
        b_idx = 0;
        for (int i = 0; i < 12; i++) begin
            send_word((i < 8) ? a[i] : b[i-8], i == 11);
            if (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input a_arr_t a, input b_arr_t b, input logic [7:0] r0,
                             input logic [7:0] r1, input bit gap);
        exp_q.push_back('{data: {24'h0, r0}, last: 1'b0});
        exp_q.push_back('{data: {24'h0, r1}, last: 1'b1});
        send_frame(a, b, gap);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_left", 32'(exp_q.size()), 0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) check($sformatf("a_ram%0d", i), 32'(a_ram[i]), 32'(a[i]));
        for (int i = 0; i < 4; i++) check($sformatf("b_ram%0d", i), 32'(b_ram[i]), 32'(b[i]));
    endtask

    initial begin
        a_arr_t a1, a2;
        b_arr_t b1, b2, b3;
        a1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        a2 = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        b1 = '{8'd1, 8'd1, 8'd1, 8'd1};
        b2 = '{8'd2, 8'd0, 8'd1, 8'd0};
        b3 = '{8'd1, 8'd2, 8'd3, 8'd4};

        reset = 1'b1;
        S_AXIS_TDATA = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(S_AXIS_TREADY), 0);
        check("rst_start", 32'(Start), 0);
        check("rst_m_tvalid", 32'(M_AXIS_TVALID), 0);
        check("rst_m_tlast", 32'(M_AXIS_TLAST), 0);
        check("rst_m_tdata", M_AXIS_TDATA, 0);
        check("rst_res_rd_en", 32'(RES_read_en), 0);
        @(negedge clk);
        reset = 1'b0;

        // ones in B: row sums 10 and 26, back-to-back output
        run_frame(a1, b1, 8'd10, 8'd26, 1'b0);

        // downstream backpressure with a 1,0,0,1 ready pattern
        rdy_mode = 1;
        run_frame(a1, b2, 8'd5, 8'd17, 1'b0);
        rdy_mode = 0;

        // gapped input valid
        run_frame(a1, b1, 8'd10, 8'd26, 1'b1);

        // asynchronous reset while the multiplier is busy
        send_frame(a2, b3, 1'b0);
        for (int i = 0; i < 50 && !Start; i++) @(posedge clk);
        check("start_seen", 32'(Start), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_start", 32'(Start), 0);
        check("arst_s_tready", 32'(S_AXIS_TREADY), 0);
        check("arst_m_tvalid", 32'(M_AXIS_TVALID), 0);
        check("arst_res_rd_en", 32'(RES_read_en), 0);
        @(negedge clk);
        reset = 1'b0;

        // two frames back to back after the abort
        run_frame(a2, b3, 8'd60, 8'd20, 1'b0);
        run_frame(a1, b2, 8'd5, 8'd17, 1'b0);

`ifdef COPROC_TLAST_CHECK_EN
        check("ferr_clear", 32'(frame_err), 0);
        a_idx = 0;
        b_idx = 0;
        for (int i = 0; i < 6; i++) send_word(a1[i], i == 5);
        repeat (3) @(posedge clk);
        #1;
        check("ferr_set", 32'(frame_err), 1);
        check("ferr_no_start", 32'(Start), 0);
        check("ferr_back_to_input", 32'(S_AXIS_TREADY), 1);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/coproc_stream_ctrl.md
Name: coproc_stream_ctrl

Overview:
- Stream-side controller for the matrix-multiply AXI Stream coprocessor.
- Receives A then B over an AXI4-Stream slave and writes them into A_RAM and B_RAM.
- Handshakes Start/Done with the multiplier, then reads RES_RAM synchronously and transmits the results on an AXI4-Stream master with TLAST on the final word.

Parameters:
- width, 8: bits per RAM location.
- A_depth_bits, 3: A_RAM address bits.
- B_depth_bits, 2: B_RAM address bits.
- RES_depth_bits, 1: RES_RAM address bits.
- A_len, 8: A words per frame (2^A_depth_bits).
- B_len, 4: B words per frame (2^B_depth_bits).
- RES_len, 2: result words per frame (2^RES_depth_bits).
- axis_width, 32: AXIS TDATA width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  axis_width  input word.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready.
- S_AXIS_TLAST  in  1  input last.
- M_AXIS_TDATA  out  axis_width  result word.
- M_AXIS_TVALID  out  1  result valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last result.
- A_write_en  out  1  A_RAM write strobe.
- A_write_address  out  A_depth_bits  A_RAM address.
- A_write_data_in  out  width  A_RAM data.
- B_write_en  out  1  B_RAM write strobe.
- B_write_address  out  B_depth_bits  B_RAM address.
- B_write_data_in  out  width  B_RAM data.
- Start  out  1  level request to the multiplier.
- Done  in  1  multiplier completion.
- RES_read_en  out  1  RES_RAM read enable.
- RES_read_address  out  RES_depth_bits  RES_RAM address.
- RES_read_data_out  in  width  RES_RAM data; 1-cycle synchronous latency; holds its value while RES_read_en is low.

Behaviour:
- Reset: state IDLE. All outputs 0; all counters 0. Reset is asynchronous and overrides everything, including mid-frame; any partial frame is discarded.
- States: IDLE -> READ_INPUTS -> COMPUTE -> WRITE_OUTPUTS -> IDLE.
- IDLE: S_AXIS_TREADY=0. Move to READ_INPUTS on the next cycle.
- READ_INPUTS:
  - S_AXIS_TREADY=1. Each beat (TVALID&TREADY) writes TDATA[width-1:0] in the same cycle; upper bits are ignored.
  - Beats 0..A_len-1 go to A_RAM at address = beat index.
  - Beats A_len..A_len+B_len-1 go to B_RAM at address = beat index - A_len.
  - Write enables are combinational from the beat and are never high outside a beat.
  - TLAST is ignored unless the optional feature is enabled.
  - After beat A_len+B_len-1, go to COMPUTE; S_AXIS_TREADY drops the following cycle.
- COMPUTE:
  - Start=1, held continuously.
  - When Done is sampled high, Start drops to 0 in the next cycle and the state moves to WRITE_OUTPUTS.
  - Done high in any other state is ignored.
- WRITE_OUTPUTS:
  - Pipeline: read address counter -> RES RAM (1 cycle) -> output register (M_AXIS_TDATA, zero-extended, with TVALID).
  - advance = !M_AXIS_TVALID | M_AXIS_TREADY.
  - RES_read_en = advance & (words issued < RES_len). The address increments on each issued read.
  - The output register loads when advance and a read was issued in the previous cycle.
  - Sustained throughput is 1 word/cycle under continuous TREADY. Under backpressure, TDATA/TVALID/TLAST hold stable.
  - M_AXIS_TLAST=1 only with word RES_len-1.
  - After that word's handshake, TVALID=0 and the state returns to IDLE. A new frame is accepted from IDLE's successor state.
- Address wrap: counters are sized exactly to their depth bits and are reset to 0 on entry to each phase. No modulo reliance across frames.

Optional Feature:
- Macro: COPROC_TLAST_CHECK_EN.
- With the macro:
  - Adds output port frame_err (1 bit, reset 0).
  - If S_AXIS_TLAST=1 on any beat other than beat A_len+B_len-1, frame_err sets and the block returns to IDLE without asserting Start.
  - If TLAST=0 on the final beat, frame_err sets but the frame proceeds normally.
  - frame_err is sticky until reset.
- Without the macro: the frame_err port is absent and TLAST is ignored.

Decomposition:
- Shared package coproc_pkg holds:
  - State encoding enum (IDLE, READ_INPUTS, COMPUTE, WRITE_OUTPUTS).
  - Default width/depth constants shared with the multiplier and the RAMs.
- Natural sub-module: res_stream_out. It holds the RES read counter, the 1-cycle read pipeline and the output register/TLAST logic. It takes a go input and gives a done output.

Test Plan:
- A=1..8, B=1,1,1,1, Done returned 5 cycles after Start, TREADY=1 -> A_RAM[0..7]=1..8, B_RAM=1s. Start high until Done, then low. Output 10 then 26, TLAST on 26, back-to-back cycles.
- Same frame with B=2,0,1,0 and TREADY toggling 1,0,0,1 -> output 5, 17. TDATA/TVALID stable during each stall; no duplicate or lost words.
- S_AXIS_TVALID gapped every other cycle -> identical RAM contents; write enables only on beats.
- reset asserted in COMPUTE with Start=1 -> Start/outputs 0 immediately (asynchronous). Next full frame processes correctly.
- Two frames back to back -> second frame's results are correct and addresses restart at 0.
- With COPROC_TLAST_CHECK_EN: TLAST on beat 5 -> frame_err=1, Start never asserted, state returns to IDLE.
